// File: rtl/voice_pkg.sv
// ============================================================================
// Module      : voice_pkg
// Description : Shared defaults and the voice record for the voice allocator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package voice_pkg;

    localparam int DEF_NUM_KEYS   = 10;
    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_AGE_W      = 8;
    localparam int KEY_IDX_W      = 4;

    typedef struct packed {
        logic                 gate;
        logic [KEY_IDX_W-1:0] key;
        logic [DEF_AGE_W-1:0] age;
    } voice_t;

endpackage

`default_nettype wire

// File: rtl/voice_age_cmp.sv
// ============================================================================
// Module      : voice_age_cmp
// Description : Combinational oldest-voice selector; ties go to lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_age_cmp
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int AGE_W      = DEF_AGE_W,
    parameter int VIDX_W     = 2
) (
    input  logic [NUM_VOICES-1:0][AGE_W-1:0] i_age,
    output logic [VIDX_W-1:0]                o_oldest
);

    logic [AGE_W-1:0] w_best;

    // Strict greater-than keeps the earliest voice on equal ages.
    always_comb begin
        w_best   = i_age[0];
        o_oldest = '0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (i_age[v] > w_best) begin
                w_best   = i_age[v];
                o_oldest = v[VIDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
// Module      : voice_allocator
// Description : Assigns held keys to a small pool of voices, one action/cycle.
//               Build macro VOICE_ALLOC_STEAL_EN enables oldest-voice stealing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int AGE_W      = DEF_AGE_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_KEYS-1:0]             i_note_in,
    input  logic                            i_tick,
    input  logic                            i_all_off,
    output logic [NUM_VOICES-1:0]           o_voice_gate,
    output logic [NUM_VOICES-1:0]           o_voice_start,
    output logic [NUM_VOICES*KEY_IDX_W-1:0] o_voice_key,
    output logic                            o_voices_full,
    output logic                            o_steal
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] c_AGE_MAX = {AGE_W{1'b1}};

    logic [NUM_KEYS-1:0]                       r_note_q;
    logic [NUM_KEYS-1:0]                       r_held;
    logic [NUM_KEYS-1:0]                       r_served;
    logic [NUM_VOICES-1:0]                     r_gate;
    logic [NUM_VOICES-1:0][KEY_IDX_W-1:0]      r_key;
    logic [NUM_VOICES-1:0][AGE_W-1:0]          r_age;
    logic [NUM_VOICES-1:0]                     r_start;
    logic                                      r_full;
    logic                                      r_steal;

    logic [NUM_KEYS-1:0]                       w_held_nx;
    logic [NUM_KEYS-1:0]                       w_served_nx;
    logic [NUM_VOICES-1:0]                     w_gate_nx;
    logic [NUM_VOICES-1:0][KEY_IDX_W-1:0]      w_key_nx;
    logic [NUM_VOICES-1:0][AGE_W-1:0]          w_age_nx;
    logic [NUM_VOICES-1:0]                     w_start_nx;
    logic                                      w_steal_nx;

    logic [NUM_KEYS-1:0]                       w_rel_vec;
    logic [NUM_KEYS-1:0]                       w_prs_vec;
    logic                                      w_rel_found;
    logic [KEY_IDX_W-1:0]                      w_rel_key;
    logic                                      w_prs_found;
    logic [KEY_IDX_W-1:0]                      w_prs_key;
    logic                                      w_free_found;
    logic [VIDX_W-1:0]                         w_free_v;
    logic [VIDX_W-1:0]                         w_old_v;

    assign w_rel_vec = r_held & ~r_note_q;
    assign w_prs_vec = r_note_q & ~r_served;

`ifdef VOICE_ALLOC_STEAL_EN
    voice_age_cmp #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .VIDX_W     (VIDX_W)
    ) u_age_cmp (
        .i_age    (r_age),
        .o_oldest (w_old_v)
    );
`else
    assign w_old_v = '0;
`endif

    // Lowest-index search: scan downward so the final hit is the lowest.
    always_comb begin
        w_rel_found  = 1'b0;
        w_rel_key    = '0;
        w_prs_found  = 1'b0;
        w_prs_key    = '0;
        w_free_found = 1'b0;
        w_free_v     = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_rel_vec[k]) begin
                w_rel_found = 1'b1;
                w_rel_key   = k[KEY_IDX_W-1:0];
            end
            if (w_prs_vec[k]) begin
                w_prs_found = 1'b1;
                w_prs_key   = k[KEY_IDX_W-1:0];
            end
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_gate[v]) begin
                w_free_found = 1'b1;
                w_free_v     = v[VIDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_held_nx   = r_held;
        w_served_nx = r_served & (r_note_q | r_held);
        w_gate_nx   = r_gate;
        w_key_nx    = r_key;
        w_age_nx    = r_age;
        w_start_nx  = '0;
        w_steal_nx  = 1'b0;

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (i_tick && r_gate[v] && (r_age[v] != c_AGE_MAX)) begin
                w_age_nx[v] = r_age[v] + 1'b1;
            end
        end

        if (i_all_off) begin
            w_gate_nx   = '0;
            w_held_nx   = '0;
            w_served_nx = '0;
        end else if (w_rel_found) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (r_gate[v] && (r_key[v] == w_rel_key)) begin
                    w_gate_nx[v] = 1'b0;
                end
            end
            w_held_nx[w_rel_key]   = 1'b0;
            w_served_nx[w_rel_key] = 1'b0;
        end else if (w_prs_found) begin
            if (w_free_found) begin
                w_gate_nx[w_free_v]  = 1'b1;
                w_key_nx[w_free_v]   = w_prs_key;
                w_age_nx[w_free_v]   = '0;
                w_start_nx[w_free_v] = 1'b1;
                w_held_nx[w_prs_key]   = 1'b1;
                w_served_nx[w_prs_key] = 1'b1;
            end
`ifdef VOICE_ALLOC_STEAL_EN
            else begin
                // The evicted key keeps served set so it is not re-requested.
                w_held_nx[r_key[w_old_v]] = 1'b0;
                w_key_nx[w_old_v]      = w_prs_key;
                w_age_nx[w_old_v]      = '0;
                w_start_nx[w_old_v]    = 1'b1;
                w_held_nx[w_prs_key]   = 1'b1;
                w_served_nx[w_prs_key] = 1'b1;
                w_steal_nx             = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_note_q <= '0;
            r_held   <= '0;
            r_served <= '0;
            r_gate   <= '0;
            r_key    <= '0;
            r_age    <= '0;
            r_start  <= '0;
            r_full   <= 1'b0;
            r_steal  <= 1'b0;
        end else begin
            r_note_q <= i_note_in;
            r_held   <= w_held_nx;
            r_served <= w_served_nx;
            r_gate   <= w_gate_nx;
            r_key    <= w_key_nx;
            r_age    <= w_age_nx;
            r_start  <= w_start_nx;
            r_full   <= &w_gate_nx;
            r_steal  <= w_steal_nx;
        end
    end

    assign o_voice_gate  = r_gate;
    assign o_voice_start = r_start;
    assign o_voice_key   = r_key;
    assign o_voices_full = r_full;
    assign o_steal       = r_steal;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// Module      : tb_voice_allocator
// Description : Scoreboard bench for voice_allocator (both steal build modes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  note;
    logic        tick;
    logic        all_off;
    logic [3:0]  voice_gate;
    logic [3:0]  voice_start;
    logic [15:0] voice_key;
    logic        voices_full;
    logic        steal;

    voice_allocator #(
        .NUM_KEYS   (10),
        .NUM_VOICES (4),
        .AGE_W      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_note_in     (note),
        .i_tick        (tick),
        .i_all_off     (all_off),
        .o_voice_gate  (voice_gate),
        .o_voice_start (voice_start),
        .o_voice_key   (voice_key),
        .o_voices_full (voices_full),
        .o_steal       (steal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  gate;
        logic [3:0]  start;
        logic [15:0] key;
        logic        full;
        logic        stl;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        act_ev;
    ev_t        exp_ev;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] prev_gate = 4'b0000;
    bit         mon_en = 1'b0;

    // Monitor: any start pulse, steal pulse or gate change is an output event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (voice_start != 4'b0 || voice_gate != prev_gate || steal) begin
                act_ev = '{voice_gate, voice_start, voice_key, voices_full, steal};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event actual gate=%b start=%b key=%h full=%b steal=%b required none",
                             act_ev.gate, act_ev.start, act_ev.key, act_ev.full, act_ev.stl);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (act_ev !== exp_ev) begin
                        n_fail++;
                        $display("FAIL event%0d actual gate=%b start=%b key=%h full=%b steal=%b required gate=%b start=%b key=%h full=%b steal=%b",
                                 n_tests, act_ev.gate, act_ev.start, act_ev.key, act_ev.full, act_ev.stl,
                                 exp_ev.gate, exp_ev.start, exp_ev.key, exp_ev.full, exp_ev.stl);
                    end
                end
            end
            prev_gate = voice_gate;
        end
    end

    task automatic expect_ev(input logic [3:0] g, input logic [3:0] s,
                             input logic [15:0] k, input logic f, input logic st);
        exp_q.push_back('{g, s, k, f, st});
    endtask

    task automatic drive_note(input logic [9:0] v, input int cycles);
        @(negedge clk);
        note = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        note    = '0;
        tick    = 1'b0;
        all_off = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({voice_gate, voice_start, voice_key, voices_full, steal} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_state actual gate=%b start=%b key=%h full=%b steal=%b required all zero",
                     voice_gate, voice_start, voice_key, voices_full, steal);
        end
        mon_en = 1'b1;

        // Single key 3, then release
        expect_ev(4'b0001, 4'b0001, 16'h0003, 1'b0, 1'b0);
        drive_note(10'h008, 6);
        expect_ev(4'b0000, 4'b0000, 16'h0003, 1'b0, 1'b0);
        drive_note(10'h000, 6);

        // Keys 0..3 together fill voices 0..3 on consecutive cycles
        expect_ev(4'b0001, 4'b0001, 16'h0000, 1'b0, 1'b0);
        expect_ev(4'b0011, 4'b0010, 16'h0010, 1'b0, 1'b0);
        expect_ev(4'b0111, 4'b0100, 16'h0210, 1'b0, 1'b0);
        expect_ev(4'b1111, 4'b1000, 16'h3210, 1'b1, 1'b0);
        drive_note(10'h00F, 8);
        repeat (4) pulse_tick();

        // Release key 0 and press key 8 together: release wins, then key 8 on voice 0
        expect_ev(4'b1110, 4'b0000, 16'h3210, 1'b0, 1'b0);
        expect_ev(4'b1111, 4'b0001, 16'h3218, 1'b1, 1'b0);
        drive_note(10'h10E, 8);
        pulse_tick();

`ifdef VOICE_ALLOC_STEAL_EN
        // Ages 1,5,5,5: key 9 steals voice 1; key 1 stays held but not re-requested
        expect_ev(4'b1111, 4'b0010, 16'h3298, 1'b1, 1'b1);
        drive_note(10'h30E, 8);
        expect_ev(4'b1011, 4'b0000, 16'h3298, 1'b0, 1'b0);
        drive_note(10'h30A, 8);
        expect_ev(4'b0011, 4'b0000, 16'h3298, 1'b0, 1'b0);
        expect_ev(4'b0010, 4'b0000, 16'h3298, 1'b0, 1'b0);
        expect_ev(4'b0000, 4'b0000, 16'h3298, 1'b0, 1'b0);
        expect_ev(4'b0001, 4'b0001, 16'h3294, 1'b0, 1'b0);
        expect_ev(4'b0011, 4'b0010, 16'h3254, 1'b0, 1'b0);
        expect_ev(4'b0111, 4'b0100, 16'h3654, 1'b0, 1'b0);
`else
        // Fifth key waits, then takes voice 2 once key 2 is released
        drive_note(10'h30E, 8);
        expect_ev(4'b1011, 4'b0000, 16'h3218, 1'b0, 1'b0);
        expect_ev(4'b1111, 4'b0100, 16'h3918, 1'b1, 1'b0);
        drive_note(10'h30A, 8);
        expect_ev(4'b1101, 4'b0000, 16'h3918, 1'b0, 1'b0);
        expect_ev(4'b0101, 4'b0000, 16'h3918, 1'b0, 1'b0);
        expect_ev(4'b0100, 4'b0000, 16'h3918, 1'b0, 1'b0);
        expect_ev(4'b0000, 4'b0000, 16'h3918, 1'b0, 1'b0);
        expect_ev(4'b0001, 4'b0001, 16'h3914, 1'b0, 1'b0);
        expect_ev(4'b0011, 4'b0010, 16'h3954, 1'b0, 1'b0);
        expect_ev(4'b0111, 4'b0100, 16'h3654, 1'b0, 1'b0);
`endif
        // All releases drain first, then keys 4,5,6 land on voices 0..2
        drive_note(10'h070, 14);

        // Panic with keys still held, then reassignment
        expect_ev(4'b0000, 4'b0000, 16'h3654, 1'b0, 1'b0);
        expect_ev(4'b0001, 4'b0001, 16'h3654, 1'b0, 1'b0);
        expect_ev(4'b0011, 4'b0010, 16'h3654, 1'b0, 1'b0);
        expect_ev(4'b0111, 4'b0100, 16'h3654, 1'b0, 1'b0);
        @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        repeat (8) @(negedge clk);

        // Mid-operation reset, keys re-request afterwards
        expect_ev(4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);
        expect_ev(4'b0001, 4'b0001, 16'h0004, 1'b0, 1'b0);
        expect_ev(4'b0011, 4'b0010, 16'h0054, 1'b0, 1'b0);
        expect_ev(4'b0111, 4'b0100, 16'h0654, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        expect_ev(4'b0110, 4'b0000, 16'h0654, 1'b0, 1'b0);
        expect_ev(4'b0100, 4'b0000, 16'h0654, 1'b0, 1'b0);
        expect_ev(4'b0000, 4'b0000, 16'h0654, 1'b0, 1'b0);
        drive_note(10'h000, 10);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_KEYS, default 10, number of note request lines.
REQ-002 Parameter NUM_VOICES, default 4, number of synthesizer voices shared among keys.
REQ-003 Parameter AGE_W, default 8, width of per-voice age counters.
REQ-004 clk  input  1  system clock; reset rst, synchronous, active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 note_in  input  NUM_KEYS  debounced key levels, bit k high = key k held.
REQ-007 tick  input  1  one-cycle time-base strobe for age counting.
REQ-008 all_off  input  1  panic: release every voice.
REQ-009 voice_gate  output  NUM_VOICES  voice v sounding.
REQ-010 voice_start  output  NUM_VOICES  one-cycle pulse on (re)assignment of voice v.
REQ-011 voice_key  output  NUM_VOICES*4  key index driven by voice v, voice v at bits [4v+3:4v].
REQ-012 voices_full  output  1  all voice_gate bits high.
REQ-013 steal  output  1  one-cycle pulse when an active voice is reassigned.

Function
REQ-014 note_in SHALL be registered once (note_q); all decisions use note_q only.
REQ-015 Internal masks: held (key owns a voice), served (key has been assigned since its last press).
REQ-016 At most one action per cycle; priority: all_off > release > press.
REQ-017 Release candidate: key set in held, clear in note_q; lowest index first; its voice_gate clears, voice_key holds its last value, served[k] clears.
REQ-018 Key clear in note_q and clear in held SHALL clear served[k] the same cycle without consuming the action slot.
REQ-019 Press candidate: key set in note_q, clear in served; lowest index first.
REQ-020 Press with a free voice: lowest-index free voice takes it; gate=1, voice_key=k, voice_start pulse, age=0, held[k]=1, served[k]=1.
REQ-021 Press with no free voice: steal voice with largest age, ties to lowest index; previous key's held bit clears (served stays set, so it is not re-requested); new key assigned as in REQ-020; steal pulses; gate stays high.
REQ-022 Latency: isolated press or release reflected on outputs 2 cycles after note_in changes.
REQ-023 Age: on tick, each gated voice age increments, saturating at 2^AGE_W-1; ungated voice age holds.
REQ-024 all_off: next cycle all gates=0, held=0, served=0, no voice_start; keys still high re-request per REQ-019 after all_off drops.
REQ-025 voices_full and steal registered, aligned with voice_gate.

Reset
REQ-026 On rst: voice_gate=0, voice_start=0, voice_key=0, voices_full=0, steal=0, note_q=0, held=0, served=0, ages=0.
REQ-027 rst mid-operation SHALL abandon all assignments without any voice_start pulse; held keys re-request after rst drops.

Configuration
REQ-028 Macro VOICE_ALLOC_STEAL_EN: defined -> stealing per REQ-021; undefined -> press with no free voice stays pending (served=0) and is assigned to the first voice freed, steal tied to 0.

Structure
REQ-029 Package voice_pkg SHALL hold NUM_KEYS/NUM_VOICES/AGE_W defaults, KEY_IDX_W=4, and a voice_t record (gate, key, age).
REQ-030 Sub-module voice_age_cmp: combinational oldest-voice selector (largest age, lowest-index tie-break).

Verification
REQ-031 Press key 3 alone -> 2 cycles later voice_gate=0001, voice_key[3:0]=3, voice_start=0001 for one cycle.
REQ-032 Keys 0,1,2,3 pressed same cycle -> assigned on consecutive cycles to voices 0..3; voices_full=1 after fourth.
REQ-033 Four voices active, ages 5,9,9,2, press key 7 -> voice 1 stolen, steal=1, voice_key[7:4]=7; old key of voice 1 not reassigned while still held.
REQ-034 Release key 0 and press key 8 same cycle with voices full -> release processed first, key 8 takes freed voice 0 next cycle, steal=0.
REQ-035 Without VOICE_ALLOC_STEAL_EN, fifth key pressed -> no change until a key releases, then fifth key gets that voice.
REQ-036 all_off with 3 voices active and keys still held -> gates 0 for the all_off cycle, keys reassigned to voices 0..2 afterwards.
